loop_nest_counter: RTL and testbench

- Generalised loop-nest iteration generator, the successor to the single-level counter and count_every_ii blocks.
- Steps an N_DIMS-deep nest of index counters through runtime-loaded trip counts, issuing one iteration every II enabled cycles.
- Exposes per-dimension indices, per-dimension wrap flags, a final-iteration flag and a done pulse.
- Drives address generation and SRAM ren/wen sequencing in generated pipelines.

---
 rtl/loop_nest_counter.sv | 110 +++++++++++
 tb/tb_loop_nest_counter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_nest_counter.sv
`default_nettype none
// ============================================================================
// loop_nest_counter: N_DIMS-deep loop-nest iteration generator, one issue per II enabled cycles
// Rev 1.0
// ============================================================================
module loop_nest_counter #(
  parameter int N_DIMS = 3,
  parameter int CW     = 16,
  parameter int II     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 en,
  input  logic [N_DIMS*CW-1:0] trips,
  output logic                 busy,
  output logic                 valid,
  output logic [N_DIMS*CW-1:0] idx,
  output logic [N_DIMS-1:0]    dim_wrap,
  output logic                 last,
  output logic                 done
);

  localparam int            PW      = $clog2(II) + 1;
  localparam logic [PW-1:0] PH_LAST = PW'(II - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state;
  logic [PW-1:0]        phase;
  logic [N_DIMS*CW-1:0] trip_q;
  logic [N_DIMS*CW-1:0] idx_nxt;
  logic [N_DIMS-1:0]    at_final;
  logic [N_DIMS-1:0]    chain;
  logic [N_DIMS-1:0]    carry;
  logic [N_DIMS-1:0]    trip_zero;

  // chain[k]: dims 0..k all sit at their final value, i.e. dim k+1 receives a carry
  genvar k;
  generate
    for (k = 0; k < N_DIMS; k++) begin : g_dim
      logic [CW-1:0] trip_k;
      logic [CW-1:0] idx_k;
      assign trip_k       = trip_q[k*CW +: CW];
      assign idx_k        = idx[k*CW +: CW];
      assign at_final[k]  = (idx_k == trip_k - CW'(1));
      assign chain[k]     = &at_final[k:0];
      assign trip_zero[k] = (trips[k*CW +: CW] == '0);
      if (k == 0) begin : g_lsb
        assign carry[k] = 1'b1;
      end else begin : g_upper
        assign carry[k] = chain[k-1];
      end
      assign idx_nxt[k*CW +: CW] = !carry[k]   ? idx_k :
                                   at_final[k] ? '0    : idx_k + CW'(1);
    end
  endgenerate

  assign busy     = (state == RUN);
  assign valid    = busy && en && (phase == '0);
  assign dim_wrap = {N_DIMS{valid}} & chain;
  assign last     = dim_wrap[N_DIMS-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      phase  <= '0;
      trip_q <= '0;
      idx    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            trip_q <= trips;
            idx    <= '0;
            phase  <= '0;
            // a zero trip count anywhere means an empty nest: report done, never issue
            if (|trip_zero) begin
              done <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (en) begin
            phase <= (phase == PH_LAST) ? '0 : phase + PW'(1);
            if (valid) begin
              idx <= idx_nxt;
              if (last) begin
                state <= IDLE;
                idx   <= '0;
                phase <= '0;
                done  <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_loop_nest_counter.sv
`default_nettype none
// ============================================================================
// tb_loop_nest_counter: drives an II=1 and an II=3 instance against an iteration-number model
// Rev 1.0
// ============================================================================
module tb_loop_nest_counter;

  localparam int CW = 16;
  localparam int ND = 3;
  localparam int W  = ND * CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_s [2];
  logic          en_s    [2];
  logic [W-1:0]  trips_s [2];
  logic          busy_o  [2];
  logic          valid_o [2];
  logic [W-1:0]  idx_o   [2];
  logic [ND-1:0] wrap_o  [2];
  logic          last_o  [2];
  logic          done_o  [2];

  int vectors = 0;
  int errors  = 0;

  // model: iteration number n of the current nest, enabled-cycle phase, latched trips
  bit     m_run  [2];
  longint m_n    [2];
  int     m_ph   [2];
  bit     m_done [2];
  longint m_t    [2][ND];

  always #5 clk = ~clk;

  loop_nest_counter #(.N_DIMS(ND), .CW(CW), .II(1)) dut_ii1 (
    .clk(clk), .rst(rst), .start(start_s[0]), .en(en_s[0]), .trips(trips_s[0]),
    .busy(busy_o[0]), .valid(valid_o[0]), .idx(idx_o[0]), .dim_wrap(wrap_o[0]),
    .last(last_o[0]), .done(done_o[0])
  );

  loop_nest_counter #(.N_DIMS(ND), .CW(CW), .II(3)) dut_ii3 (
    .clk(clk), .rst(rst), .start(start_s[1]), .en(en_s[1]), .trips(trips_s[1]),
    .busy(busy_o[1]), .valid(valid_o[1]), .idx(idx_o[1]), .dim_wrap(wrap_o[1]),
    .last(last_o[1]), .done(done_o[1])
  );

  function automatic int ii_of(int s);
    return (s == 0) ? 1 : 3;
  endfunction

  function automatic logic [W-1:0] mk_trips(int t0, int t1, int t2);
    return {16'(t2), 16'(t1), 16'(t0)};
  endfunction

  function automatic logic [W-1:0] rnd_trips(bit zero_ok);
    logic [W-1:0] t;
    for (int k = 0; k < ND; k++)
      t[k*CW +: CW] = (zero_ok && $urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 3));
    return t;
  endfunction

  // expected {busy, valid, idx, dim_wrap, last, done}; idx_k = (n / prod_{j<k} t_j) mod t_k
  function automatic logic [W+ND+2:0] exp_vec(int s);
    logic          v;
    logic [W-1:0]  ix;
    logic [ND-1:0] w;
    longint        p;
    v  = m_run[s] && en_s[s] && (m_ph[s] == 0);
    ix = '0;
    w  = '0;
    p  = 1;
    for (int k = 0; k < ND; k++) begin
      if (m_run[s]) ix[k*CW +: CW] = 16'((m_n[s] / p) % m_t[s][k]);
      p = p * m_t[s][k];
      if (v) w[k] = ((m_n[s] + 1) % p) == 0;
    end
    return {m_run[s], v, ix, w, w[ND-1], m_done[s]};
  endfunction

  function automatic logic [W+ND+2:0] obs_vec(int s);
    return {busy_o[s], valid_o[s], idx_o[s], wrap_o[s], last_o[s], done_o[s]};
  endfunction

  task automatic model_update();
    for (int s = 0; s < 2; s++) begin
      bit     nd;
      bit     anyz;
      longint total;
      nd = 1'b0;
      if (rst) begin
        m_run[s] = 1'b0;
        m_n[s]   = 0;
        m_ph[s]  = 0;
      end else if (!m_run[s]) begin
        if (start_s[s]) begin
          anyz = 1'b0;
          for (int k = 0; k < ND; k++) begin
            m_t[s][k] = longint'(trips_s[s][k*CW +: CW]);
            if (m_t[s][k] == 0) anyz = 1'b1;
          end
          m_n[s]  = 0;
          m_ph[s] = 0;
          if (anyz) nd = 1'b1;
          else      m_run[s] = 1'b1;
        end
      end else if (en_s[s]) begin
        total = 1;
        for (int k = 0; k < ND; k++) total = total * m_t[s][k];
        if (m_ph[s] == 0) begin
          if (m_n[s] + 1 == total) begin
            m_run[s] = 1'b0;
            m_n[s]   = 0;
            nd       = 1'b1;
          end else begin
            m_n[s] = m_n[s] + 1;
          end
        end
        m_ph[s] = m_run[s] ? (m_ph[s] + 1) % ii_of(s) : 0;
      end
      m_done[s] = nd;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    for (int c = 0; c < 4; c++) begin
      if (c == 2) rst = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        vectors++;
        if (obs_vec(s) !== exp_vec(s)) begin
          errors++;
          $display("FAIL reset dut%0d c=%0d got %h want %h", s, c, obs_vec(s), exp_vec(s));
        end
      end
      tick();
    end
  endtask

  task automatic test_basic_nest();
    trips_s[0] = mk_trips(3, 2, 2);
    en_s[0]    = 1'b1;
    for (int c = 0; c < 16; c++) begin
      start_s[0] = (c == 0);
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        vectors++;
        if (obs_vec(s) !== exp_vec(s)) begin
          errors++;
          $display("FAIL basic_nest dut%0d c=%0d got %h want %h", s, c, obs_vec(s), exp_vec(s));
        end
      end
      tick();
    end
  endtask

  task automatic test_ii3();
    trips_s[1] = mk_trips(2, 1, 1);
    en_s[1]    = 1'b1;
    for (int c = 0; c < 8; c++) begin
      start_s[1] = (c == 0);
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        vectors++;
        if (obs_vec(s) !== exp_vec(s)) begin
          errors++;
          $display("FAIL ii3 dut%0d c=%0d got %h want %h", s, c, obs_vec(s), exp_vec(s));
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [6:0] pat;
    pat        = 7'b1110010;
    trips_s[0] = mk_trips(4, 1, 1);
    for (int c = 0; c < 160; c++) begin
      if (c < 10) begin
        start_s[0] = (c == 0);
        en_s[0]    = (c < 7) ? pat[c] : 1'b1;
      end else begin
        for (int s = 0; s < 2; s++) begin
          start_s[s] = !m_run[s] && ($urandom_range(0, 1) == 1);
          trips_s[s] = rnd_trips(1'b0);
          en_s[s]    = ($urandom_range(0, 3) != 0);
        end
      end
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        vectors++;
        if (obs_vec(s) !== exp_vec(s)) begin
          errors++;
          $display("FAIL stall dut%0d c=%0d got %h want %h", s, c, obs_vec(s), exp_vec(s));
        end
      end
      tick();
    end
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    en_s[0]    = 1'b1;
    en_s[1]    = 1'b1;
    repeat (40) tick();
  endtask

  task automatic test_zero_trip();
    trips_s[0] = mk_trips(5, 0, 2);
    trips_s[1] = mk_trips(1, 1, 0);
    for (int c = 0; c < 4; c++) begin
      start_s[0] = (c == 0);
      start_s[1] = (c == 0);
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        vectors++;
        if (obs_vec(s) !== exp_vec(s)) begin
          errors++;
          $display("FAIL zero_trip dut%0d c=%0d got %h want %h", s, c, obs_vec(s), exp_vec(s));
        end
      end
      tick();
    end
  endtask

  task automatic test_start_ignored();
    bit relaunched;
    relaunched = 1'b0;
    en_s[0]    = 1'b1;
    for (int c = 0; c < 40; c++) begin
      start_s[0] = 1'b0;
      if (c == 0) begin
        start_s[0] = 1'b1;
        trips_s[0] = mk_trips(3, 2, 2);
      end else if (c == 4) begin
        start_s[0] = 1'b1;
        trips_s[0] = mk_trips(1, 1, 1);
      end else if (m_done[0] && !relaunched) begin
        start_s[0] = 1'b1;
        trips_s[0] = rnd_trips(1'b0);
        relaunched = 1'b1;
      end
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        vectors++;
        if (obs_vec(s) !== exp_vec(s)) begin
          errors++;
          $display("FAIL start_ignored dut%0d c=%0d got %h want %h", s, c, obs_vec(s), exp_vec(s));
        end
      end
      tick();
    end
    vectors++;
    if (relaunched !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored_done_seen got %0b want 1", relaunched);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < 2; s++) begin
        start_s[s] = ($urandom_range(0, 2) == 0);
        trips_s[s] = rnd_trips(1'b1);
        en_s[s]    = ($urandom_range(0, 7) != 0);
      end
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        vectors++;
        if (obs_vec(s) !== exp_vec(s)) begin
          errors++;
          $display("FAIL back_to_back dut%0d c=%0d got %h want %h", s, c, obs_vec(s), exp_vec(s));
        end
      end
      tick();
    end
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    en_s[0]    = 1'b1;
    en_s[1]    = 1'b1;
    repeat (40) tick();
  endtask

  task automatic test_reset_mid();
    bit fired;
    fired   = 1'b0;
    en_s[0] = 1'b1;
    en_s[1] = 1'b1;
    for (int c = 0; c < 32; c++) begin
      start_s[0] = (c == 0) || (c == 12);
      start_s[1] = (c == 0);
      trips_s[0] = mk_trips(3, 2, 2);
      trips_s[1] = mk_trips(16'hFFFF, 2, 1);
      rst        = 1'b0;
      if (!fired && m_run[0] && m_n[0] == 4) begin
        rst   = 1'b1;
        fired = 1'b1;
      end
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        vectors++;
        if (obs_vec(s) !== exp_vec(s)) begin
          errors++;
          $display("FAIL reset_mid dut%0d c=%0d got %h want %h", s, c, obs_vec(s), exp_vec(s));
        end
      end
      tick();
    end
    rst = 1'b0;
    vectors++;
    if (fired !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_fifth_valid_reached got %0b want 1", fired);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      start_s[s] = 1'b0;
      en_s[s]    = 1'b0;
      trips_s[s] = '0;
      m_run[s]   = 1'b0;
      m_n[s]     = 0;
      m_ph[s]    = 0;
      m_done[s]  = 1'b0;
      for (int k = 0; k < ND; k++) m_t[s][k] = 1;
    end
    test_reset();
    test_basic_nest();
    test_ii3();
    test_stall();
    test_zero_trip();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
